// File: rtl/tow_round_ctrl.sv
// Round sequencer for the Tug-of-War game. It runs the wait/armed round cycle,
// scores early and on-time pushes, moves the rope, and latches the match winner.
module tow_round_ctrl #(
    parameter int POS_W    = 4,
    parameter int POS_MAX  = 8,
    parameter int CNT_W    = 8,
    parameter int WAIT_CYC = 100
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             pushl,
    input  logic             pushr,
    output logic [POS_W-1:0] pos,
    output logic             ready,
    output logic             foul,
    output logic             winl,
    output logic             winr
);

    localparam logic [POS_W-1:0] CENTRE  = POS_W'(POS_MAX / 2);
    localparam logic [POS_W-1:0] POS_TOP = POS_W'(POS_MAX);
    localparam logic [CNT_W-1:0] RELOAD  = CNT_W'(WAIT_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_ARMED,
        S_CHECK,
        S_OVER
    } state_t;

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [POS_W-1:0] pos_n;
    logic             ready_n, foul_n, winl_n, winr_n;

    always_comb begin
        // NOTE: every next-state value takes a default first so no path infers a latch.
        state_n = state;
        cnt_n   = cnt;
        pos_n   = pos;
        ready_n = ready;
        foul_n  = 1'b0;
        winl_n  = winl;
        winr_n  = winr;

        case (state)
            S_IDLE: begin
                if (start) begin
                    state_n = S_WAIT;
                    pos_n   = CENTRE;
                    cnt_n   = RELOAD;
                end
            end

            // An early push gives the point to the opponent; a foul beats cnt==0.
            S_WAIT: begin
                if (pushl && !pushr) begin
                    foul_n  = 1'b1;
                    pos_n   = pos + 1'b1;
                    state_n = S_CHECK;
                end else if (pushr && !pushl) begin
                    foul_n  = 1'b1;
                    pos_n   = pos - 1'b1;
                    state_n = S_CHECK;
                end else if (pushl && pushr) begin
                    cnt_n = RELOAD;
                end else if (cnt == '0) begin
                    state_n = S_ARMED;
                    ready_n = 1'b1;
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end

            S_ARMED: begin
                if (pushl && pushr) begin
                    state_n = S_WAIT;
                    cnt_n   = RELOAD;
                    ready_n = 1'b0;
                end else if (pushl) begin
                    pos_n   = pos - 1'b1;
                    state_n = S_CHECK;
                    ready_n = 1'b0;
                end else if (pushr) begin
                    pos_n   = pos + 1'b1;
                    state_n = S_CHECK;
                    ready_n = 1'b0;
                end
            end

            S_CHECK: begin
                if (pos == '0) begin
                    state_n = S_OVER;
                    winl_n  = 1'b1;
                end else if (pos == POS_TOP) begin
                    state_n = S_OVER;
                    winr_n  = 1'b1;
                end else begin
                    state_n = S_WAIT;
                    cnt_n   = RELOAD;
                end
            end

            S_OVER: begin
                if (start) begin
                    winl_n  = 1'b0;
                    winr_n  = 1'b0;
                    pos_n   = CENTRE;
                    state_n = S_WAIT;
                    cnt_n   = RELOAD;
                end
            end

            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (rst) begin
            state <= S_IDLE;
            cnt   <= '0;
            pos   <= CENTRE;
            ready <= 1'b0;
            foul  <= 1'b0;
            winl  <= 1'b0;
            winr  <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            pos   <= pos_n;
            ready <= ready_n;
            foul  <= foul_n;
            winl  <= winl_n;
            winr  <= winr_n;
        end
    end

endmodule

// File: tb/tb_tow_round_ctrl.sv
// Bench for tow_round_ctrl: directed vector table, hand-written win/reset
// sequences, and a randomized run checked against a round-level reference model.
module tb_tow_round_ctrl;

    localparam int POS_W    = 4;
    localparam int POS_MAX  = 8;
    localparam int CNT_W    = 8;
    localparam int WAIT_CYC = 4;
    localparam int CENTRE   = POS_MAX / 2;

    logic             clk;
    logic             rst;
    logic             start;
    logic             pushl;
    logic             pushr;
    logic [POS_W-1:0] pos;
    logic             ready;
    logic             foul;
    logic             winl;
    logic             winr;

    tow_round_ctrl #(
        .POS_W   (POS_W),
        .POS_MAX (POS_MAX),
        .CNT_W   (CNT_W),
        .WAIT_CYC(WAIT_CYC)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .pushl(pushl),
        .pushr(pushr),
        .pos  (pos),
        .ready(ready),
        .foul (foul),
        .winl (winl),
        .winr (winr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s (cycle %0d): got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    // Reference model: tracks the round as "cycles of waiting left", an armed
    // lamp, a pending judgement and the winner flags.
    int m_pos;
    int m_wait_left;
    bit m_ready, m_foul, m_winl, m_winr, m_judging;

    task automatic model_step(input bit r, input bit s, input bit l, input bit p);
        m_foul = 1'b0;
        if (r) begin
            m_pos = CENTRE; m_ready = 0; m_winl = 0; m_winr = 0;
            m_wait_left = 0; m_judging = 0;
        end else if (m_judging) begin
            m_judging = 0;
            if (m_pos == 0)            m_winl = 1;
            else if (m_pos == POS_MAX) m_winr = 1;
            else                       m_wait_left = WAIT_CYC;
        end else if (m_winl || m_winr) begin
            if (s) begin
                m_winl = 0; m_winr = 0; m_pos = CENTRE; m_wait_left = WAIT_CYC;
            end
        end else if (m_ready) begin
            if (l && p) begin
                m_ready = 0; m_wait_left = WAIT_CYC;
            end else if (l || p) begin
                m_pos += l ? -1 : 1;
                m_ready = 0; m_judging = 1;
            end
        end else if (m_wait_left > 0) begin
            if (l && p) begin
                m_wait_left = WAIT_CYC;
            end else if (l || p) begin
                m_foul = 1;
                m_pos += l ? 1 : -1;
                m_wait_left = 0; m_judging = 1;
            end else begin
                m_wait_left--;
                if (m_wait_left == 0) m_ready = 1;
            end
        end else if (s) begin
            m_pos = CENTRE; m_wait_left = WAIT_CYC;
        end
    endtask

    // One clock: drive on the falling edge, sample 1 time unit after the rising edge.
    task automatic apply(input bit r, input bit s, input bit l, input bit p);
        @(negedge clk);
        rst = r; start = s; pushl = l; pushr = p;
        model_step(r, s, l, p);
        @(posedge clk);
        #1;
        cyc++;
        check("model_pos",   int'(pos),   m_pos);
        check("model_ready", int'(ready), int'(m_ready));
        check("model_foul",  int'(foul),  int'(m_foul));
        check("model_winl",  int'(winl),  int'(m_winl));
        check("model_winr",  int'(winr),  int'(m_winr));
    endtask

    task automatic wait_ready(input string name);
        for (int i = 0; i < 20 && !m_ready; i++) apply(0, 0, 0, 0);
        check(name, int'(ready), 1);
    endtask

    typedef struct {
        bit r, s, l, p;
        int pos;
        bit ready, foul, winl, winr;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(bit r, bit s, bit l, bit p, int ps, bit rd, bit f, bit wl, bit wr);
        vec_t v;
        v.r = r; v.s = s; v.l = l; v.p = p;
        v.pos = ps; v.ready = rd; v.foul = f; v.winl = wl; v.winr = wr;
        return v;
    endfunction

    initial begin
        rst = 1'b1; start = 1'b0; pushl = 1'b0; pushr = 1'b0;

        //                 r s l p  pos rdy foul wl wr
        vecs.push_back(mk(1,0,0,0, 4, 0, 0, 0, 0));  // reset
        vecs.push_back(mk(1,0,0,0, 4, 0, 0, 0, 0));
        vecs.push_back(mk(0,0,1,0, 4, 0, 0, 0, 0));  // pushes ignored in IDLE
        vecs.push_back(mk(0,0,0,1, 4, 0, 0, 0, 0));
        vecs.push_back(mk(0,1,0,0, 4, 0, 0, 0, 0));  // start -> WAIT
        vecs.push_back(mk(0,0,0,0, 4, 0, 0, 0, 0));
        vecs.push_back(mk(0,0,0,0, 4, 0, 0, 0, 0));
        vecs.push_back(mk(0,0,0,0, 4, 0, 0, 0, 0));
        vecs.push_back(mk(0,0,0,0, 4, 1, 0, 0, 0));  // ready 4 edges after entry
        vecs.push_back(mk(0,0,0,0, 4, 1, 0, 0, 0));
        vecs.push_back(mk(0,1,0,0, 4, 1, 0, 0, 0));  // start ignored in ARMED
        vecs.push_back(mk(0,0,1,0, 3, 0, 0, 0, 0));  // left point
        vecs.push_back(mk(0,0,0,0, 3, 0, 0, 0, 0));  // CHECK -> WAIT
        vecs.push_back(mk(0,0,0,0, 3, 0, 0, 0, 0));
        vecs.push_back(mk(0,0,1,0, 4, 0, 1, 0, 0));  // early left push: foul
        vecs.push_back(mk(0,0,0,0, 4, 0, 0, 0, 0));
        vecs.push_back(mk(0,0,0,0, 4, 0, 0, 0, 0));
        vecs.push_back(mk(0,0,0,0, 4, 0, 0, 0, 0));
        vecs.push_back(mk(0,0,0,0, 4, 0, 0, 0, 0));
        vecs.push_back(mk(0,0,0,0, 4, 1, 0, 0, 0));
        vecs.push_back(mk(0,0,1,1, 4, 0, 0, 0, 0));  // tie in ARMED
        vecs.push_back(mk(0,0,0,0, 4, 0, 0, 0, 0));
        vecs.push_back(mk(0,0,0,0, 4, 0, 0, 0, 0));
        vecs.push_back(mk(0,0,0,0, 4, 0, 0, 0, 0));
        vecs.push_back(mk(0,0,0,0, 4, 1, 0, 0, 0));  // full 4-cycle wait again
        vecs.push_back(mk(0,0,0,1, 5, 0, 0, 0, 0));  // right point
        vecs.push_back(mk(0,0,0,0, 5, 0, 0, 0, 0));
        vecs.push_back(mk(0,0,0,0, 5, 0, 0, 0, 0));
        vecs.push_back(mk(0,0,1,1, 5, 0, 0, 0, 0));  // tie in WAIT: reload, no foul
        vecs.push_back(mk(0,0,0,0, 5, 0, 0, 0, 0));
        vecs.push_back(mk(0,0,0,0, 5, 0, 0, 0, 0));
        vecs.push_back(mk(0,0,0,0, 5, 0, 0, 0, 0));
        vecs.push_back(mk(0,0,0,0, 5, 1, 0, 0, 0));

        foreach (vecs[i]) begin
            apply(vecs[i].r, vecs[i].s, vecs[i].l, vecs[i].p);
            check($sformatf("vec%0d_pos", i),   int'(pos),   vecs[i].pos);
            check($sformatf("vec%0d_ready", i), int'(ready), int'(vecs[i].ready));
            check($sformatf("vec%0d_foul", i),  int'(foul),  int'(vecs[i].foul));
            check($sformatf("vec%0d_winl", i),  int'(winl),  int'(vecs[i].winl));
            check($sformatf("vec%0d_winr", i),  int'(winr),  int'(vecs[i].winr));
        end

        // Four on-time left pushes from centre win the match.
        apply(1, 0, 0, 0);
        apply(0, 1, 0, 0);
        for (int k = 0; k < 4; k++) begin
            wait_ready("win_ready_seen");
            apply(0, 0, 1, 0);
        end
        check("win_last_pos",   int'(pos),  0);
        check("win_flag_early", int'(winl), 0);
        apply(0, 0, 0, 0);
        check("win_flag",       int'(winl), 1);
        check("win_no_winr",    int'(winr), 0);
        apply(0, 0, 1, 0);
        apply(0, 0, 0, 1);
        check("over_pos_frozen", int'(pos),  0);
        check("over_winl_held",  int'(winl), 1);
        apply(0, 1, 0, 0);
        check("restart_winl", int'(winl), 0);
        check("restart_pos",  int'(pos),  CENTRE);

        // Reset mid-WAIT and mid-ARMED.
        apply(0, 0, 0, 0);
        apply(1, 0, 0, 0);
        check("rst_wait_pos",   int'(pos),   CENTRE);
        check("rst_wait_ready", int'(ready), 0);
        apply(0, 1, 0, 0);
        wait_ready("rst_armed_ready_seen");
        apply(0, 0, 0, 1);
        wait_ready("rst_armed_ready_seen2");
        apply(1, 0, 0, 0);
        check("rst_armed_pos",   int'(pos),   CENTRE);
        check("rst_armed_ready", int'(ready), 0);
        apply(0, 0, 1, 0);
        check("idle_after_rst_pos", int'(pos), CENTRE);

        // Randomized play with a slowly changing bias toward one side.
        begin
            int bias = 0;
            for (int i = 0; i < 3000; i++) begin
                bit r, s, l, p;
                if (i % 150 == 0) bias = int'($urandom_range(0, 2));
                r = ($urandom_range(0, 299) == 0);
                s = ($urandom_range(0, 7) == 0);
                l = ($urandom_range(0, (bias == 1) ? 2 : 6) == 0);
                p = ($urandom_range(0, (bias == 2) ? 2 : 6) == 0);
                apply(r, s, l, p);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
